// File: rtl/img_pkg.sv
// Shared types and defaults for the image frame buffer.
package img_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned IMG_W_DEF  = 4;
   localparam int unsigned IMG_H_DEF  = 4;

   // Default-width pixel beat: payload plus frame/line markers
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  sof;
      logic                  eol;
      logic                  eof;
   } pix_beat_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } strm_state_t;

   // Counter width for a range of n values, never below one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/img_skid_fifo.sv
// Two-entry valid/ready skid FIFO; head is a register so it drives outputs directly.
module img_skid_fifo
   import img_pkg::*;
#(
   parameter type beat_t = pix_beat_t
)
(
   input  logic  clock,
   input  logic  reset_n,
   input  beat_t in_beat,
   input  logic  push,
   input  logic  pop,
   output beat_t head,
   output logic  full,
   output logic  empty
);

   logic [1:0] cnt;
   logic [1:0] cnt_nxt_c;
   logic       push_ok_c;
   logic       pop_ok_c;
   beat_t      tail;

   // Accepted push/pop and next occupancy
   always_comb begin
      pop_ok_c  = pop & ~empty;
      push_ok_c = push & (~full | pop_ok_c);
      cnt_nxt_c = cnt + 2'(push_ok_c) - 2'(pop_ok_c);
   end

   // Head/tail storage; head is cleared when the FIFO drains
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt   <= 2'd0;
         full  <= 1'b0;
         empty <= 1'b1;
         head  <= '0;
         tail  <= '0;
      end else begin
         cnt   <= cnt_nxt_c;
         full  <= (cnt_nxt_c == 2'd2);
         empty <= (cnt_nxt_c == 2'd0);
         if (pop_ok_c) begin
            if (cnt == 2'd2) begin
               head <= tail;
               if (push_ok_c) tail <= in_beat;
            end else if (push_ok_c) begin
               head <= in_beat;
            end else begin
               head <= '0;
            end
         end else if (push_ok_c) begin
            if (cnt == 2'd0) head <= in_beat;
            else             tail <= in_beat;
         end
      end
   end

endmodule

// File: rtl/img_frame_buffer.sv
// Image frame buffer: write port, random read port and raster streaming engine.
module img_frame_buffer
   import img_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned IMG_W     = IMG_W_DEF,
   parameter int unsigned IMG_H     = IMG_H_DEF,
   parameter string       INIT_FILE = "image.hex",
   localparam int unsigned ADDR_W   = $clog2(IMG_W * IMG_H)
)
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   input  logic              start,
   output logic              busy,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              done
);

   localparam int unsigned DEPTH = IMG_W * IMG_H;
   localparam int unsigned XW    = cnt_w(IMG_W);
   localparam int unsigned AW1   = ADDR_W + 1;

   localparam logic [AW1-1:0]    DEPTH_A = AW1'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
   localparam logic [XW-1:0]     LAST_X  = XW'(IMG_W - 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sof;
      logic              eol;
      logic              eof;
   } beat_t;

   logic [DATA_W-1:0] mem [DEPTH];

   strm_state_t       state;
   logic [ADDR_W-1:0] iss_addr;
   logic [XW-1:0]     iss_x;
   logic              iss_all;
   logic              rd_valid;
   beat_t             rd_beat;
   beat_t             head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_c;
   logic              room_c;
   logic              issue_c;

   localparam string unused_init_file = INIT_FILE;

   // Write port; out-of-range addresses are dropped
   always_ff @(posedge clock) begin
      if (we && ({1'b0, wraddress} < DEPTH_A)) mem[wraddress] <= data;
   end

   // Random read port, only served while the stream engine is idle
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= re & ~busy;
         if (re && !busy) q <= ({1'b0, rdaddress} < DEPTH_A) ? mem[rdaddress] : '0;
      end
   end

   // Issue a stream read when FIFO plus in-flight read leaves a free slot after this pop
   always_comb begin
      pop_c   = ~fifo_empty & pix_ready;
      room_c  = ~fifo_full & ~(~fifo_empty & rd_valid);
      issue_c = (state == RUN) & ~iss_all & (room_c | pop_c);
   end

   // Stream FSM, raster counters and read-data stage
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         iss_addr <= '0;
         iss_x    <= '0;
         iss_all  <= 1'b0;
         rd_valid <= 1'b0;
         rd_beat  <= '0;
      end else begin
         done     <= 1'b0;
         rd_valid <= issue_c;
         if (issue_c) begin
            rd_beat.data <= mem[iss_addr];
            rd_beat.sof  <= (iss_addr == '0);
            rd_beat.eol  <= (iss_x == LAST_X);
            rd_beat.eof  <= (iss_addr == LAST_A);
            iss_addr     <= iss_addr + ADDR_W'(1);
            iss_x        <= (iss_x == LAST_X) ? '0 : iss_x + XW'(1);
            iss_all      <= (iss_addr == LAST_A);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  iss_addr <= '0;
                  iss_x    <= '0;
                  iss_all  <= 1'b0;
               end
            end
            RUN: begin
               if (pop_c && head.eof) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   img_skid_fifo #(
      .beat_t (beat_t)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .in_beat (rd_beat),
      .push    (rd_valid),
      .pop     (pop_c),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign pix_valid = ~fifo_empty;
   assign pix_data  = head.data;
   assign pix_sof   = head.sof;
   assign pix_eol   = head.eol;
   assign pix_eof   = head.eof;

endmodule

// File: tb/tb_img_frame_buffer.sv
// Bench for img_frame_buffer: frame-level model for the default instance plus
// directed checks on a 12-bit 8x2 instance and a 5x1 instance.
module tb_img_frame_buffer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   bit rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   // Default instance
   logic       d0_reset_n, d0_we, d0_re, d0_start, d0_pix_ready;
   logic [7:0] d0_data, d0_q, d0_pix_data;
   logic [3:0] d0_wraddress, d0_rdaddress;
   logic       d0_q_valid, d0_busy, d0_pix_sof, d0_pix_eol, d0_pix_eof, d0_pix_valid, d0_done;

   // 12-bit, 8x2 instance
   logic        d1_reset_n, d1_we, d1_re, d1_start, d1_pix_ready;
   logic [11:0] d1_data, d1_q, d1_pix_data;
   logic [3:0]  d1_wraddress, d1_rdaddress;
   logic        d1_q_valid, d1_busy, d1_pix_sof, d1_pix_eol, d1_pix_eof, d1_pix_valid, d1_done;

   // 8-bit, 5x1 instance
   logic       d2_reset_n, d2_we, d2_re, d2_start, d2_pix_ready;
   logic [7:0] d2_data, d2_q, d2_pix_data;
   logic [2:0] d2_wraddress, d2_rdaddress;
   logic       d2_q_valid, d2_busy, d2_pix_sof, d2_pix_eol, d2_pix_eof, d2_pix_valid, d2_done;

   img_frame_buffer u_dut0 (
      .clock(clock), .reset_n(d0_reset_n), .data(d0_data), .wraddress(d0_wraddress), .we(d0_we),
      .re(d0_re), .rdaddress(d0_rdaddress), .q(d0_q), .q_valid(d0_q_valid), .start(d0_start),
      .busy(d0_busy), .pix_data(d0_pix_data), .pix_sof(d0_pix_sof), .pix_eol(d0_pix_eol),
      .pix_eof(d0_pix_eof), .pix_valid(d0_pix_valid), .pix_ready(d0_pix_ready), .done(d0_done)
   );

   img_frame_buffer #(.DATA_W(12), .IMG_W(8), .IMG_H(2)) u_dut1 (
      .clock(clock), .reset_n(d1_reset_n), .data(d1_data), .wraddress(d1_wraddress), .we(d1_we),
      .re(d1_re), .rdaddress(d1_rdaddress), .q(d1_q), .q_valid(d1_q_valid), .start(d1_start),
      .busy(d1_busy), .pix_data(d1_pix_data), .pix_sof(d1_pix_sof), .pix_eol(d1_pix_eol),
      .pix_eof(d1_pix_eof), .pix_valid(d1_pix_valid), .pix_ready(d1_pix_ready), .done(d1_done)
   );

   img_frame_buffer #(.DATA_W(8), .IMG_W(5), .IMG_H(1)) u_dut2 (
      .clock(clock), .reset_n(d2_reset_n), .data(d2_data), .wraddress(d2_wraddress), .we(d2_we),
      .re(d2_re), .rdaddress(d2_rdaddress), .q(d2_q), .q_valid(d2_q_valid), .start(d2_start),
      .busy(d2_busy), .pix_data(d2_pix_data), .pix_sof(d2_pix_sof), .pix_eol(d2_pix_eol),
      .pix_eof(d2_pix_eof), .pix_valid(d2_pix_valid), .pix_ready(d2_pix_ready), .done(d2_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: outputs after the next edge are stable on return, inputs may be driven
   task automatic cyc();
      @(negedge clock);
      #1;
   endtask

   // Frame-level model of the default instance
   logic [7:0] mem_m [16];
   logic [7:0] q_m;
   bit         busy_m, qv_m, prev_valid;
   int         k_m;

   // Predicts outputs after each edge from the inputs sampled at that edge
   always @(negedge clock) begin
      bit xfer;
      bit done_m;
      xfer   = 1'b0;
      done_m = 1'b0;
      if (!d0_reset_n) begin
         busy_m = 1'b0;
         k_m    = 0;
         q_m    = 8'h00;
         qv_m   = 1'b0;
      end else begin
         xfer = prev_valid && d0_pix_ready;
         qv_m = d0_re && !busy_m;
         if (qv_m) q_m = mem_m[d0_rdaddress];
         if (!busy_m && d0_start) begin
            busy_m = 1'b1;
            k_m    = 0;
         end else if (xfer) begin
            if (k_m == 15) begin
               busy_m = 1'b0;
               done_m = 1'b1;
               k_m    = 0;
            end else begin
               k_m++;
            end
         end
         if (d0_we) mem_m[d0_wraddress] = d0_data;
      end
      chk("m_q", d0_q, q_m);
      chk("m_q_valid", d0_q_valid, qv_m);
      chk("m_busy", d0_busy, busy_m);
      chk("m_done", d0_done, done_m);
      if (busy_m && d0_pix_valid) begin
         chk("m_pix_data", d0_pix_data, mem_m[k_m]);
         chk("m_pix_sof", d0_pix_sof, k_m == 0);
         chk("m_pix_eol", d0_pix_eol, (k_m % 4) == 3);
         chk("m_pix_eof", d0_pix_eof, k_m == 15);
      end else if (!busy_m) begin
         chk("m_pix_valid_idle", d0_pix_valid, 1'b0);
      end
      prev_valid = d0_pix_valid;
   end

   task automatic d0_run_to_done(input int bound);
      int n;
      n = 0;
      while (!d0_done && n < bound) begin
         cyc();
         n++;
      end
      chk("d0_done_seen", d0_done, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g;
      int j;
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      d0_reset_n = 0; d0_we = 0; d0_re = 0; d0_start = 0; d0_pix_ready = 1;
      d0_data = '0; d0_wraddress = '0; d0_rdaddress = '0;
      d1_reset_n = 0; d1_we = 0; d1_re = 0; d1_start = 0; d1_pix_ready = 1;
      d1_data = '0; d1_wraddress = '0; d1_rdaddress = '0;
      d2_reset_n = 0; d2_we = 0; d2_re = 0; d2_start = 0; d2_pix_ready = 1;
      d2_data = '0; d2_wraddress = '0; d2_rdaddress = '0;
      cyc();
      cyc();
      chk("rst_q", d0_q, 8'h00);
      chk("rst_q_valid", d0_q_valid, 1'b0);
      chk("rst_busy", d0_busy, 1'b0);
      chk("rst_pix_valid", d0_pix_valid, 1'b0);
      chk("rst_done", d0_done, 1'b0);
      d0_reset_n = 1; d1_reset_n = 1; d2_reset_n = 1;

      // Load and read back the default frame
      for (int i = 0; i < 16; i++) begin
         d0_we = 1; d0_wraddress = 4'(i); d0_data = 8'(8'h10 + i);
         cyc();
      end
      d0_we = 0;
      for (int i = 0; i < 16; i++) begin
         d0_re = 1; d0_rdaddress = 4'(i);
         cyc();
         chk("t1_q", d0_q, 8'h10 + i);
         chk("t1_q_valid", d0_q_valid, 1'b1);
      end
      d0_re = 0;
      cyc();
      chk("t1_q_valid_clear", d0_q_valid, 1'b0);
      chk("t1_q_hold", d0_q, 8'h1F);

      // Read-during-write returns the old word
      d0_we = 1; d0_wraddress = 4'd2; d0_data = 8'hAA; d0_re = 1; d0_rdaddress = 4'd2;
      cyc();
      chk("rdw_old", d0_q, 8'h12);
      d0_we = 0;
      cyc();
      chk("rdw_new", d0_q, 8'hAA);
      d0_re = 0; d0_we = 1; d0_data = 8'h12;
      cyc();
      d0_we = 0;
      cyc();

      // Full-rate frame with literal timing
      d0_start = 1;
      cyc();
      chk("t2_busy", d0_busy, 1'b1);
      chk("t2_valid_e0", d0_pix_valid, 1'b0);
      d0_start = 0;
      cyc();
      chk("t2_valid_e1", d0_pix_valid, 1'b0);
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk("t2_valid", d0_pix_valid, 1'b1);
         chk("t2_data", d0_pix_data, 8'h10 + k);
         chk("t2_sof", d0_pix_sof, k == 0);
         chk("t2_eol", d0_pix_eol, (k == 3) || (k == 7) || (k == 11) || (k == 15));
         chk("t2_eof", d0_pix_eof, k == 15);
      end
      cyc();
      chk("t2_done", d0_done, 1'b1);
      chk("t2_busy_end", d0_busy, 1'b0);
      chk("t2_valid_end", d0_pix_valid, 1'b0);
      cyc();
      chk("t2_done_pulse", d0_done, 1'b0);

      // Backpressure pattern
      d0_start = 1;
      cyc();
      d0_start = 0;
      n = 0; g = 0; j = 0;
      while (!d0_done && g < 200) begin
         d0_pix_ready = rdy_pat[j % 6];
         j++;
         if (d0_pix_valid && d0_pix_ready) begin
            chk("t3_order", d0_pix_data, 8'h10 + n);
            n++;
         end
         cyc();
         g++;
      end
      chk("t3_count", n, 16);
      chk("t3_done", d0_done, 1'b1);
      d0_pix_ready = 1;
      cyc();

      // start+re while idle, then start/re pulses mid-stream
      d0_start = 1; d0_re = 1; d0_rdaddress = 4'd7;
      cyc();
      chk("t4_q", d0_q, 8'h17);
      chk("t4_q_valid", d0_q_valid, 1'b1);
      chk("t4_busy", d0_busy, 1'b1);
      d0_start = 0; d0_re = 0;
      cyc(); cyc(); cyc();
      d0_start = 1; d0_re = 1; d0_rdaddress = 4'd3;
      cyc();
      chk("t4_q_valid_busy", d0_q_valid, 1'b0);
      chk("t4_q_hold", d0_q, 8'h17);
      d0_start = 0; d0_re = 0;
      d0_run_to_done(40);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t4_no_refire_valid", d0_pix_valid, 1'b0);
         chk("t4_no_refire_busy", d0_busy, 1'b0);
      end

      // Reset mid-frame, then replay from pixel 0
      d0_start = 1;
      cyc();
      d0_start = 0;
      n = 0; g = 0;
      while (n < 6 && g < 50) begin
         if (d0_pix_valid && d0_pix_ready) n++;
         cyc();
         g++;
      end
      chk("t5_beats", n, 6);
      d0_reset_n = 0;
      cyc();
      chk("t5_busy", d0_busy, 1'b0);
      chk("t5_valid", d0_pix_valid, 1'b0);
      chk("t5_data", d0_pix_data, 8'h00);
      chk("t5_markers", {d0_pix_sof, d0_pix_eol, d0_pix_eof}, 3'b000);
      chk("t5_q", d0_q, 8'h00);
      chk("t5_done", d0_done, 1'b0);
      d0_reset_n = 1;
      cyc();
      cyc();
      chk("t5_no_done", d0_done, 1'b0);
      d0_start = 1;
      cyc();
      d0_start = 0;
      cyc();
      cyc();
      chk("t5_replay_data", d0_pix_data, 8'h10);
      chk("t5_replay_sof", d0_pix_sof, 1'b1);
      d0_run_to_done(40);

      // 12-bit 8x2 instance
      for (int i = 0; i < 16; i++) begin
         d1_we = 1; d1_wraddress = 4'(i); d1_data = 12'(12'hA50 + i);
         cyc();
      end
      d1_we = 0; d1_re = 1; d1_rdaddress = 4'd9;
      cyc();
      chk("d1_q", d1_q, 12'hA59);
      d1_re = 0; d1_start = 1;
      cyc();
      d1_start = 0;
      cyc();
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk("d1_valid", d1_pix_valid, 1'b1);
         chk("d1_data", d1_pix_data, 12'hA50 + k);
         chk("d1_sof", d1_pix_sof, k == 0);
         chk("d1_eol", d1_pix_eol, (k == 7) || (k == 15));
         chk("d1_eof", d1_pix_eof, k == 15);
      end
      cyc();
      chk("d1_done", d1_done, 1'b1);
      chk("d1_busy", d1_busy, 1'b0);

      // 5x1 instance: out-of-range addresses and single-line frame
      for (int i = 0; i < 5; i++) begin
         d2_we = 1; d2_wraddress = 3'(i); d2_data = 8'(8'h20 + i);
         cyc();
      end
      for (int a = 5; a < 8; a++) begin
         d2_we = 1; d2_wraddress = 3'(a); d2_data = 8'hEE;
         cyc();
      end
      d2_we = 0; d2_re = 1; d2_rdaddress = 3'd6;
      cyc();
      chk("d2_oor_q", d2_q, 8'h00);
      chk("d2_oor_q_valid", d2_q_valid, 1'b1);
      d2_rdaddress = 3'd0;
      cyc();
      chk("d2_q0", d2_q, 8'h20);
      d2_re = 0; d2_start = 1;
      cyc();
      d2_start = 0;
      cyc();
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("d2_valid", d2_pix_valid, 1'b1);
         chk("d2_data", d2_pix_data, 8'h20 + k);
         chk("d2_sof", d2_pix_sof, k == 0);
         chk("d2_eol", d2_pix_eol, k == 4);
         chk("d2_eof", d2_pix_eof, k == 4);
      end
      cyc();
      chk("d2_done", d2_done, 1'b1);
      chk("d2_busy", d2_busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
